// File: rtl/match_evt_pkg.sv
// Shared definitions for the match event recorder.
// Record layout: {start[TS_W-1:0], len[LEN_W-1:0]}, start field in the MSBs.
package match_evt_pkg;

  // Run tracker states
  // state | meaning
  // IDLE  | no run in progress, waiting for a rising edge of the match flag
  // RUN   | match flag high, accumulating the current run length
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  // Total packed record width: start field followed by length field.
  function automatic int rec_w(input int ts_w, input int len_w);
    return ts_w + len_w;
  endfunction

  // Saturation value of the run-length field (all ones).
  function automatic int unsigned len_max(input int unsigned len_w);
    return (32'd1 << len_w) - 32'd1;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Head data is driven from registered storage; reads as zero when empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
// A pop while empty is ignored, so a push into an empty FIFO always lands.
module evt_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign rdata    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; pointers wrap naturally at power-of-2 DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/match_event_fifo.sv
// Timestamps runs of the pattern-detector match flag and queues
// {start, length} records in an FWFT FIFO with a sticky overflow flag.
// Optional build macro MATCH_EVT_SPLIT_EN: a run reaching the maximum length
// emits a max-length record and continues as a fresh record in the same cycle;
// without it the length saturates and one record is emitted per run.
module match_event_fifo
  import match_evt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   match_in,
  input  logic                   pop,
  input  logic                   clear_ovf,
  output logic                   evt_valid,
  output logic [TS_W-1:0]        evt_start,
  output logic [LEN_W-1:0]       evt_len,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int             REC_W   = rec_w(TS_W, LEN_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(len_max(LEN_W));

  run_state_t       state, state_n;
  logic [TS_W-1:0]  ts;
  logic             match_q;
  logic [TS_W-1:0]  cur_start, cur_start_n;
  logic [LEN_W-1:0] cur_len, cur_len_n;
  logic             push;
  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;

  // Free-running timestamp and previous-cycle copy of the match flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts      <= '0;
      match_q <= 1'b0;
    end else begin
      ts      <= ts + TS_W'(1);
      match_q <= match_in;
    end
  end

  // Run tracker state and current-record registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_start <= '0;
      cur_len   <= '0;
    end else begin
      state     <= state_n;
      cur_start <= cur_start_n;
      cur_len   <= cur_len_n;
    end
  end

  // Run tracker next state; a record is emitted from the pre-update fields.
  always_comb begin
    state_n     = state;
    cur_start_n = cur_start;
    cur_len_n   = cur_len;
    push        = 1'b0;
    rec         = {cur_start, cur_len};
    case (state)
      IDLE: begin
        if (match_in && !match_q) begin
          cur_start_n = ts;
          cur_len_n   = LEN_W'(1);
          state_n     = RUN;
        end
      end
      RUN: begin
        if (match_in) begin
`ifdef MATCH_EVT_SPLIT_EN
          if (cur_len == LEN_MAX) begin
            push        = 1'b1;
            cur_start_n = ts;
            cur_len_n   = LEN_W'(1);
          end else begin
            cur_len_n = cur_len + LEN_W'(1);
          end
`else
          if (cur_len != LEN_MAX) cur_len_n = cur_len + LEN_W'(1);
`endif
        end else begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  evt_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (rec),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign evt_valid = !fifo_empty;
  assign evt_start = head[REC_W-1 -: TS_W];
  assign evt_len   = head[LEN_W-1:0];

  // Sticky overflow: a dropped record sets it, and setting beats clearing.
  always_ff @(posedge clk) begin
    if (reset)                            overflow <= 1'b0;
    else if (push && fifo_full && !pop)   overflow <= 1'b1;
    else if (clear_ovf)                   overflow <= 1'b0;
  end

endmodule
